// File: rtl/mux2t1_arb_pkg.sv
// mux2t1_arb_pkg
//   Shared types and constants for the two-requester arbitrating mux.
//   state_t : output stage state (IDLE = no beat held, HOLD = F holds a beat)
//   SEL_A/B : encoding of the Sel output and the round-robin history bit
//   WIDTH_DEF / CNT_W_DEF : default data and counter widths
package mux2t1_arb_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int CNT_W_DEF = 8;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/mux2t1_8b.sv
// mux2t1_8b
//   Plain combinational 2:1 data mux.
//   A, B : data inputs
//   Sel  : 0 selects A, 1 selects B
//   F    : selected data
module mux2t1_8b #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Sel,
  output logic [WIDTH-1:0] F
);

  assign F = Sel ? B : A;

endmodule

// File: rtl/mux2t1_arb.sv
// mux2t1_arb
//   Two-requester arbiter feeding a registered one-entry output stage.
//   Requests are granted combinationally whenever the output register can
//   take a beat; the winner's data lands in F one cycle later.
//   Ports:
//     Clk, Rst        : rising-edge clock, synchronous active-high reset
//     ReqA/ReqB, A/B  : requester valid and data
//     GntA/GntB       : combinational grant (ready) back to the requesters
//     F, FValid       : registered selected data and its valid
//     FReady          : downstream accepts F
//     Sel             : source of current F (0 = A, 1 = B)
//     CntA/CntB       : saturating accepted-beat counters
//   Build option: MUX2T1_ARB_FIXED_PRIO_EN makes A always win contention;
//   otherwise contention is resolved round-robin.
module mux2t1_arb
  import mux2t1_arb_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             ReqA,
  input  logic             ReqB,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             GntA,
  output logic             GntB,
  output logic [WIDTH-1:0] F,
  output logic             FValid,
  input  logic             FReady,
  output logic             Sel,
  output logic [CNT_W-1:0] CntA,
  output logic [CNT_W-1:0] CntB
);

  state_t           state, state_nxt;
  logic             last_sel;
  logic             can_accept;
  logic             win_b;
  logic             beat;
  logic             xfer;
  logic [WIDTH-1:0] mux_out;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  assign can_accept = !FValid || FReady;
  assign xfer       = FValid && FReady;

`ifdef MUX2T1_ARB_FIXED_PRIO_EN
  assign win_b = ReqB && !ReqA;
`else
  // Under contention B wins only if A had the previous beat.
  assign win_b = ReqB && (!ReqA || (last_sel == SEL_A));
`endif

  // Grants are gated by Rst so nothing is handed out while the block resets.
  assign GntA = !Rst && can_accept && ReqA && !win_b;
  assign GntB = !Rst && can_accept && win_b;
  assign beat = GntA || GntB;

  mux2t1_8b #(.WIDTH(WIDTH)) u_mux (
    .A  (A),
    .B  (B),
    .Sel(win_b),
    .F  (mux_out)
  );

  // State register
  always_ff @(posedge Clk) begin
    if (Rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (beat) state_nxt = HOLD;
      HOLD:    if (xfer && !beat) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    FValid = (state == HOLD);
  end

  // Datapath: F/Sel/history only move on a beat, so they hold under
  // backpressure and after a drained transfer.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      F        <= '0;
      Sel      <= SEL_A;
      last_sel <= SEL_B;
    end else if (beat) begin
      F        <= mux_out;
      Sel      <= win_b;
      last_sel <= win_b;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      CntA <= '0;
      CntB <= '0;
    end else begin
      if (GntA && CntA != CNT_MAX) CntA <= CntA + 1'b1;
      if (GntB && CntB != CNT_MAX) CntB <= CntB + 1'b1;
    end
  end

endmodule

// File: tb/tb_mux2t1_arb.sv
// tb_mux2t1_arb
//   Directed self-checking bench for mux2t1_arb. Inputs change and outputs
//   are sampled on the falling edge; the DUT acts on the rising edge.
//   Honours MUX2T1_ARB_FIXED_PRIO_EN for the contention expectations.
module tb_mux2t1_arb;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       ReqA, ReqB;
  logic [7:0] A, B;
  logic       GntA, GntB;
  logic [7:0] F;
  logic       FValid;
  logic       FReady;
  logic       Sel;
  logic [7:0] CntA, CntB;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  mux2t1_arb #(.WIDTH(8), .CNT_W(8)) dut (
    .Clk(Clk), .Rst(Rst), .ReqA(ReqA), .ReqB(ReqB), .A(A), .B(B),
    .GntA(GntA), .GntB(GntB), .F(F), .FValid(FValid), .FReady(FReady),
    .Sel(Sel), .CntA(CntA), .CntB(CntB)
  );

  task automatic do_reset();
    @(negedge Clk);
    Rst = 1'b1; ReqA = 1'b0; ReqB = 1'b0; A = '0; B = '0; FReady = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge Clk);
    Rst = 1'b1; ReqA = 1'b1; ReqB = 1'b1; A = 8'h12; B = 8'h34; FReady = 1'b1;
    @(negedge Clk);
    @(negedge Clk);
    checks++; if (F !== 8'h00) begin errors++; $display("FAIL reset_f got=%h exp=00", F); end
    checks++; if (FValid !== 1'b0) begin errors++; $display("FAIL reset_fvalid got=%b exp=0", FValid); end
    checks++; if (CntA !== 8'd0 || CntB !== 8'd0) begin errors++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", CntA, CntB); end
    checks++; if (GntA !== 1'b0 || GntB !== 1'b0) begin errors++; $display("FAIL reset_gnt got=%b%b exp=00", GntA, GntB); end
    checks++; if (Sel !== 1'b0) begin errors++; $display("FAIL reset_sel got=%b exp=0", Sel); end
    ReqA = 1'b0; ReqB = 1'b0;
    Rst = 1'b0;
  endtask

  task automatic test_single();
    @(negedge Clk);
    ReqA = 1'b1; A = 8'hAA; FReady = 1'b1;
    #1;
    checks++; if (GntA !== 1'b1 || GntB !== 1'b0) begin errors++; $display("FAIL single_gnt got=%b%b exp=10", GntA, GntB); end
    @(negedge Clk);
    ReqA = 1'b0;
    checks++; if (F !== 8'hAA) begin errors++; $display("FAIL single_f got=%h exp=aa", F); end
    checks++; if (Sel !== 1'b0 || FValid !== 1'b1) begin errors++; $display("FAIL single_sel_valid got=%b%b exp=01", Sel, FValid); end
    checks++; if (CntA !== 8'd1) begin errors++; $display("FAIL single_cnt got=%0d exp=1", CntA); end
    @(negedge Clk);
    // delivered with no new beat: drains, data holds
    checks++; if (FValid !== 1'b0 || F !== 8'hAA) begin errors++; $display("FAIL single_drain got v=%b f=%h exp v=0 f=aa", FValid, F); end
  endtask

  task automatic test_contention();
    logic [7:0] exp_f [4];
`ifdef MUX2T1_ARB_FIXED_PRIO_EN
    exp_f = '{8'hF0, 8'hF0, 8'hF0, 8'hF0};
`else
    exp_f = '{8'hF0, 8'h0F, 8'hF0, 8'h0F};
`endif
    do_reset();
    @(negedge Clk);
    ReqA = 1'b1; ReqB = 1'b1; A = 8'hF0; B = 8'h0F; FReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      checks++; if (F !== exp_f[i] || FValid !== 1'b1) begin
        errors++; $display("FAIL contention_f[%0d] got=%h v=%b exp=%h v=1", i, F, FValid, exp_f[i]);
      end
    end
    ReqA = 1'b0; ReqB = 1'b0;
`ifdef MUX2T1_ARB_FIXED_PRIO_EN
    checks++; if (CntA !== 8'd4 || CntB !== 8'd0) begin errors++; $display("FAIL contention_cnt got=%0d/%0d exp=4/0", CntA, CntB); end
`else
    checks++; if (CntA !== 8'd2 || CntB !== 8'd2) begin errors++; $display("FAIL contention_cnt got=%0d/%0d exp=2/2", CntA, CntB); end
`endif
  endtask

  // Starts with FValid=1 left over from the contention run.
  task automatic test_backpressure();
    logic [7:0] held;
`ifdef MUX2T1_ARB_FIXED_PRIO_EN
    held = 8'hF0;
`else
    held = 8'h0F;
`endif
    FReady = 1'b0;
    @(negedge Clk);
    ReqB = 1'b1; B = 8'h55;
    #1;
    checks++; if (GntB !== 1'b0 || GntA !== 1'b0) begin errors++; $display("FAIL bp_gnt_blocked got=%b%b exp=00", GntA, GntB); end
    @(negedge Clk);
    checks++; if (F !== held || FValid !== 1'b1) begin errors++; $display("FAIL bp_hold got f=%h v=%b exp f=%h v=1", F, FValid, held); end
    FReady = 1'b1;
    #1;
    checks++; if (GntB !== 1'b1) begin errors++; $display("FAIL bp_gnt_release got=%b exp=1", GntB); end
    @(negedge Clk);
    ReqB = 1'b0;
    checks++; if (F !== 8'h55 || Sel !== 1'b1 || FValid !== 1'b1) begin
      errors++; $display("FAIL bp_new_beat got f=%h sel=%b v=%b exp f=55 sel=1 v=1", F, Sel, FValid);
    end
    @(negedge Clk);
    checks++; if (FValid !== 1'b0) begin errors++; $display("FAIL bp_drain got=%b exp=0", FValid); end
  endtask

  task automatic test_saturation();
    do_reset();
    @(negedge Clk);
    ReqA = 1'b1; FReady = 1'b1;
    for (int i = 0; i < 260; i++) begin
      A = 8'(i);
      @(negedge Clk);
    end
    ReqA = 1'b0;
    checks++; if (CntA !== 8'd255 || CntB !== 8'd0) begin errors++; $display("FAIL sat_cnt got=%0d/%0d exp=255/0", CntA, CntB); end
    checks++; if (F !== 8'h03) begin errors++; $display("FAIL sat_last_f got=%h exp=03", F); end
  endtask

  task automatic test_reset_mid();
    @(negedge Clk);
    FReady = 1'b0; ReqA = 1'b1; A = 8'h77;
    @(negedge Clk);
    checks++; if (FValid !== 1'b1 || F !== 8'h77) begin errors++; $display("FAIL mid_setup got v=%b f=%h exp v=1 f=77", FValid, F); end
    Rst = 1'b1;
    #1;
    checks++; if (GntA !== 1'b0) begin errors++; $display("FAIL mid_gnt got=%b exp=0", GntA); end
    @(negedge Clk);
    checks++; if (FValid !== 1'b0 || F !== 8'h00) begin errors++; $display("FAIL mid_out got v=%b f=%h exp v=0 f=00", FValid, F); end
    checks++; if (CntA !== 8'd0 || CntB !== 8'd0) begin errors++; $display("FAIL mid_cnt got=%0d/%0d exp=0/0", CntA, CntB); end
    Rst = 1'b0; ReqA = 1'b0; FReady = 1'b1;
    @(negedge Clk);
  endtask

  initial begin
    Rst = 1'b1; ReqA = 1'b0; ReqB = 1'b0; A = '0; B = '0; FReady = 1'b0;
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_saturation();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mux2t1_arb.md
MUX2T1_ARB -- requirements
Module: mux2t1_arb

Interface
REQ-001 Parameter WIDTH, default 8, data width of both requester channels and the output.
REQ-002 Parameter CNT_W, default 8, width of the per-channel beat counters.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset.
REQ-004 Port Clk, input, 1, rising-edge clock.
REQ-005 Port Rst, input, 1, synchronous active-high reset.
REQ-006 Ports ReqA/ReqB, input, 1 each, requester valid.
REQ-007 Ports A/B, input, WIDTH each, requester data.
REQ-008 Ports GntA/GntB, output, 1 each, combinational grant (ready).
REQ-009 Port F, output, WIDTH, registered selected data.
REQ-010 Port FValid, output, 1, F holds an undelivered beat.
REQ-011 Port FReady, input, 1, downstream accepts F.
REQ-012 Port Sel, output, 1, source of current F: 0 = A, 1 = B.
REQ-013 Ports CntA/CntB, output, CNT_W each, accepted-beat counters.

Function
REQ-014 Beat: ReqX and GntX high at the same rising edge; output transfer: FValid and FReady high at the same rising edge.
REQ-015 can_accept = !FValid || FReady; GntA and GntB SHALL both be 0 when can_accept is 0.
REQ-016 Winner: only one request active -> that requester wins; both active -> the requester not equal to LastSel wins (round-robin).
REQ-017 At most one of GntA/GntB SHALL be high in any cycle; GntX SHALL be 0 whenever ReqX is 0.
REQ-018 On a beat, the next cycle has F = winner data, Sel = winner, FValid = 1, LastSel = winner. Latency is 1 cycle from grant to FValid.
REQ-019 Output transfer with no new beat in the same cycle: FValid <= 0; F and Sel hold their values.
REQ-020 Output transfer and new beat in the same cycle: FValid stays 1 and F is replaced. With FReady held high, throughput is 1 beat per cycle.
REQ-021 FValid = 1 and FReady = 0: F, Sel and FValid SHALL hold stable.
REQ-022 A requester SHALL hold ReqX and its data stable until granted. The block does not check this.
REQ-023 FSM states: IDLE (FValid = 0) and HOLD (FValid = 1).
  - IDLE -> HOLD on a beat.
  - HOLD -> IDLE on an output transfer with no beat.
  - Otherwise the state is unchanged.
REQ-024 CntX increments on each beat of channel X and saturates at 2^CNT_W-1 (no wrap-around).

Reset
REQ-025 Rst at a clock edge SHALL force:
  - F = 0, FValid = 0, Sel = 0, state IDLE;
  - LastSel = 1, so A wins the first contention;
  - CntA = CntB = 0.
REQ-026 While Rst is high, GntA and GntB SHALL be 0. A beat in flight at reset is discarded.

Configuration
REQ-027 Macro MUX2T1_ARB_FIXED_PRIO_EN:
  - When defined, A SHALL always win contention and LastSel has no effect.
  - When undefined, round-robin per REQ-016 applies.

Structure
REQ-028 Package mux2t1_arb_pkg SHALL hold the state typedef (IDLE, HOLD), SEL_A = 0 / SEL_B = 1 constants and the WIDTH/CNT_W defaults.
REQ-029 Data selection SHALL use one instance of the existing mux2t1_8b (A, B, Sel, F), driven by the winner select, feeding the F register.

Verification
REQ-030 Reset check: after Rst, F = 0x00, FValid = 0, CntA = CntB = 0, GntA = GntB = 0.
REQ-031 Single requester: ReqA = 1 with A = 0xAA and FReady = 1 -> GntA = 1, next cycle F = 0xAA, Sel = 0, FValid = 1, CntA = 1.
REQ-032 Contention: ReqA = ReqB = 1 with A = 0xF0, B = 0x0F and FReady = 1 for 4 cycles -> F sequence 0xF0, 0x0F, 0xF0, 0x0F, CntA = CntB = 2. With MUX2T1_ARB_FIXED_PRIO_EN defined -> F = 0xF0 for all 4 cycles, CntB = 0.
REQ-033 Backpressure: FReady = 0 with FValid = 1 and ReqB = 1 -> GntB = 0 and F stable. Raising FReady -> GntB = 1 in that cycle and F = B on the next cycle.
REQ-034 Saturation: 260 beats on A -> CntA = 255.
REQ-035 Reset mid-operation: FValid = 1 with FReady = 0, assert Rst -> next cycle FValid = 0, F = 0x00, counters 0.
